// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source FIFO-buffered round-robin arbiter for the common data bus.
// ALU is source 0, LSB is source 1; one registered CDB beat per popped entry.
module cdb_arbiter #(
  parameter int ROB_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_val,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_val,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_val,
  output logic             cdb_src
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ROB_W + 32;

  logic [1:0]    w_in_valid;
  logic [1:0]    w_ready;
  logic [1:0]    w_has;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [EW-1:0] w_in_data [2];
  logic [EW-1:0] w_head    [2];
  logic          w_grant_alu;
  logic          w_grant_lsb;
  logic          r_last_lsb;

  assign w_in_valid   = {lsb_valid, alu_valid};
  assign w_in_data[0] = {alu_rob_id, alu_val};
  assign w_in_data[1] = {lsb_rob_id, lsb_val};
  assign alu_ready    = w_ready[0];
  assign lsb_ready    = w_ready[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // Ready comes from the registered count only, so a full FIFO never takes a pass-through push.
    assign w_ready[s] = r_cnt < CW'(DEPTH);
    assign w_has[s]   = r_cnt != '0;
    assign w_push[s]  = w_in_valid[s] & w_ready[s] & rdy_in & ~flush_in;
    assign w_head[s]  = r_mem[r_rp];

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else if (rdy_in) begin
        if (flush_in) begin
          r_wp  <= '0;
          r_rp  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push[s]) r_wp <= r_wp + AW'(1);
          if (w_pop[s])  r_rp <= r_rp + AW'(1);
          case ({w_push[s], w_pop[s]})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end

    always_ff @(posedge clk_in) begin
      if (w_push[s]) r_mem[r_wp] <= w_in_data[s];
    end
  end

  // Grant depends on FIFO contents only; ties go to the source not granted last.
  assign w_grant_alu = w_has[0] & (~w_has[1] | r_last_lsb);
  assign w_grant_lsb = w_has[1] & ~w_grant_alu;
  assign w_pop       = {w_grant_lsb, w_grant_alu} & {2{rdy_in & ~flush_in}};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= 1'b0;
      r_last_lsb <= 1'b1;
    end else if (rdy_in) begin
      if (flush_in) begin
        cdb_valid  <= 1'b0;
        r_last_lsb <= 1'b1;
      end else if (w_grant_alu) begin
        cdb_valid             <= 1'b1;
        {cdb_rob_id, cdb_val} <= w_head[0];
        cdb_src               <= 1'b0;
        r_last_lsb            <= 1'b0;
      end else if (w_grant_lsb) begin
        cdb_valid             <= 1'b1;
        {cdb_rob_id, cdb_val} <= w_head[1];
        cdb_src               <= 1'b1;
        r_last_lsb            <= 1'b1;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the single common data bus (CDB) between the two result producers of the out-of-order core: the ALU (driven by RS issue) and the load/store buffer (load results). Each producer pushes into a private small FIFO. A round-robin arbiter pops at most one entry per cycle and broadcasts it as a registered CDB beat to ROB, RS and LSB. A ROB-driven flush discards all pending results.

Parameters:
ROB_W, 4, width of a ROB index (matches the ROB index range used by decode/RS/LSB).
DEPTH, 2, entries per source FIFO; power of two, >= 2.

Ports:
clk_in  input  1  clock, all state on rising edge.
rst_in  input  1  reset, asynchronous, active-low.
rdy_in  input  1  global enable; 0 freezes all state.
flush_in  input  1  misprediction flush from ROB.
alu_valid  input  1  ALU result offered.
alu_rob_id  input  ROB_W  destination ROB entry.
alu_val  input  32  result value.
alu_ready  output  1  ALU FIFO can accept.
lsb_valid  input  1  load result offered.
lsb_rob_id  input  ROB_W  destination ROB entry.
lsb_val  input  32  loaded value.
lsb_ready  output  1  LSB FIFO can accept.
cdb_valid  output  1  broadcast beat valid.
cdb_rob_id  output  ROB_W  ROB entry completed.
cdb_val  output  32  value broadcast.
cdb_src  output  1  0 = ALU, 1 = LSB.

Behaviour:
- Reset (rst_in low, asynchronous, no clock needed): both FIFO counts/pointers 0, cdb_valid 0, cdb_rob_id 0, cdb_val 0, cdb_src 0, round-robin pointer = "LSB granted last", so ALU wins the first tie. alu_ready and lsb_ready are 1 once reset is asserted.
- xx_ready = (count_xx < DEPTH), derived from registered count only. A full FIFO does not accept a push even when it pops in the same cycle (no pass-through).
- Push: valid && ready && rdy_in && !flush_in at a rising edge writes {rob_id, val} at the tail. The tail pointer wraps modulo DEPTH. Count width is clog2(DEPTH)+1.
- Arbitration on each edge with rdy_in=1 and flush_in=0:
  - Neither head present: cdb_valid <= 0.
  - One head present: that head is popped and registered onto the CDB.
  - Both heads present: grant the source not granted last, then update the pointer. The pointer updates only on a contested grant or a single grant; it is held when there is no grant.
- CDB outputs are registered. A winner's cdb_valid is high for exactly one cycle per popped entry.
- Latency: a push at edge k appears on the CDB after edge k+1 at the earliest.
- Per-source order is preserved (FIFO). Fairness: a present head waits at most one grant. Arbitration decisions depend on FIFO contents only, never on same-cycle inputs.
- flush_in=1 with rdy_in=1 at an edge:
  - Both FIFOs are emptied and cdb_valid <= 0.
  - Same-cycle pushes are dropped.
  - The round-robin pointer returns to its reset value.
  - Flush overrides push and pop.
- rdy_in=0: no push, no pop, no flush action. All registers hold, including cdb_* (a valid beat stays asserted). ready outputs keep reflecting the held counts.
- Simultaneous push and pop on one source: count unchanged, both pointers advance. This is legal when count < DEPTH.
- cdb_rob_id, cdb_val and cdb_src keep their last values when cdb_valid=0. Consumers must qualify them with cdb_valid.

Test Plan:
1. Single push: after reset, ALU pushes rob_id 3, val 0x12345678 at edge 1. Required: after edge 2, cdb_valid=1, rob_id 3, val 0x12345678, src 0. After edge 3, cdb_valid=0.
2. Contention: both sources push every cycle (ALU ids 0,1,2…; LSB ids 8,9,10…). Required: CDB sources alternate ALU,LSB,ALU,… starting with ALU. Per-source ids appear in order, with no loss or duplication.
3. Backpressure: DEPTH=2, both sources stream continuously. Required: alu_ready falls to 0 once count=2 and the stalled data is held until accepted. Total CDB beats equal the number of accepted pushes.
4. Flush: both FIFOs hold 2 entries and flush_in is pulsed one cycle while both valids are high. Required: next cycle cdb_valid=0 and both ready=1. No pre-flush or same-cycle id ever appears on the CDB. The first later contested grant goes to ALU.
5. rdy_in low for 3 cycles while cdb_valid=1 with pending entries. Required: cdb_* and counts are frozen. Arbitration resumes on the first edge with rdy_in=1, in the same order it would have followed.
6. Asynchronous reset mid-stream: drop rst_in between clock edges. Required: cdb_valid=0 and counts 0 immediately, with no edge. After release, the first contested grant goes to ALU.
